// File: rtl/aes_round_ctrl.sv
// ----------------------------------------------------------------------------
// aes_round_ctrl
//   Round sequencer for an iterative AES-128 datapath. After a start handshake
//   it runs the initial AddRoundKey (INIT), NUM_ROUNDS-1 full rounds (ROUND)
//   and one final round without MixColumns (FINAL). It then holds out_valid
//   (DONE) until the consumer accepts the result. It holds no data bits.
//
// Ports
//   CLK, RSTB     clock (rising edge), asynchronous active-low reset
//   start_valid   host requests a block          start_ready  accepting (IDLE)
//   abort         synchronous cancel to IDLE
//   load_sel      datapath selects plaintext^key / cipher key (INIT)
//   state_en      state register load enable     key_en       round-key enable
//   mix_en        MixColumns in path             rcon         round constant
//   round_idx     current round, 0 = initial AddRoundKey
//   busy          INIT / ROUND / FINAL
//   out_valid     ciphertext valid (DONE)        out_ready    consumer accepts
// ----------------------------------------------------------------------------
module aes_round_ctrl #(
   parameter int NUM_ROUNDS = 10,
   parameter int RW         = 4
) (
   input  logic          CLK,
   input  logic          RSTB,
   input  logic          start_valid,
   output logic          start_ready,
   input  logic          abort,
   output logic          load_sel,
   output logic          state_en,
   output logic          key_en,
   output logic          mix_en,
   output logic [7:0]    rcon,
   output logic [RW-1:0] round_idx,
   output logic          busy,
   output logic          out_valid,
   input  logic          out_ready
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INIT  = 3'd1,
      S_ROUND = 3'd2,
      S_FINAL = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [RW-1:0] LAST_FULL = RW'(NUM_ROUNDS - 1);

   state_t        state, nxt;
   logic [RW-1:0] nidx;
   logic [7:0]    nrcon;

   // GF(2^8) doubling used by the key-schedule round constant
   function automatic logic [7:0] xtime(input logic [7:0] x);
      xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

   // Next state plus the round counter / rcon that go with it. Abort wins
   // over everything, including a start in IDLE and a pending DONE result.
   always_comb begin
      nxt   = state;
      nidx  = round_idx;
      nrcon = rcon;
      if (abort) begin
         nxt   = S_IDLE;
         nidx  = '0;
         nrcon = 8'h00;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start_valid) nxt = S_INIT;
            end
            S_INIT: begin
               nxt   = S_ROUND;
               nidx  = RW'(1);
               nrcon = 8'h01;
            end
            S_ROUND: begin
               // round_idx reaches NUM_ROUNDS exactly when FINAL is entered
               nidx  = round_idx + RW'(1);
               nrcon = xtime(rcon);
               if (round_idx == LAST_FULL) nxt = S_FINAL;
            end
            S_FINAL: begin
               nxt   = S_DONE;
               nrcon = xtime(rcon);
            end
            S_DONE: begin
               if (out_ready) begin
                  nxt   = S_IDLE;
                  nidx  = '0;
                  nrcon = 8'h00;
               end
            end
            default: begin
               nxt   = S_IDLE;
               nidx  = '0;
               nrcon = 8'h00;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so each one is a flop that
   // lines up with the registered state it describes.
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state       <= S_IDLE;
         round_idx   <= '0;
         rcon        <= 8'h00;
         start_ready <= 1'b1;
         load_sel    <= 1'b0;
         state_en    <= 1'b0;
         key_en      <= 1'b0;
         mix_en      <= 1'b0;
         busy        <= 1'b0;
         out_valid   <= 1'b0;
      end else begin
         state       <= nxt;
         round_idx   <= nidx;
         rcon        <= nrcon;
         start_ready <= (nxt == S_IDLE);
         load_sel    <= (nxt == S_INIT);
         state_en    <= (nxt == S_INIT) || (nxt == S_ROUND) || (nxt == S_FINAL);
         key_en      <= (nxt == S_INIT) || (nxt == S_ROUND) || (nxt == S_FINAL);
         mix_en      <= (nxt == S_ROUND);
         busy        <= (nxt == S_INIT) || (nxt == S_ROUND) || (nxt == S_FINAL);
         out_valid   <= (nxt == S_DONE);
      end
   end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ----------------------------------------------------------------------------
// tb_aes_round_ctrl
//   Three controller instances (NUM_ROUNDS = 10, 2, 14) on one clock/reset.
//   Each cycle of a block is compared against a cycle-indexed reference built
//   from the round schedule: cycle k after the start handshake is INIT (k=1),
//   ROUND k-1 (2..N), FINAL (N+1) or DONE (N+2 onward).
// ----------------------------------------------------------------------------
module tb_aes_round_ctrl;

   typedef struct packed {
      logic       sr, ls, se, ke, me;
      logic [7:0] rc;
      logic [3:0] ri;
      logic       bz, ov;
   } obs_t;

   logic       CLK = 1'b0;
   logic       RSTB;
   logic       sv  [3];
   logic       ab  [3];
   logic       ordy[3];
   logic       sr  [3];
   logic       ls  [3];
   logic       se  [3];
   logic       ke  [3];
   logic       me  [3];
   logic [7:0] rc  [3];
   logic [3:0] ri  [3];
   logic       bz  [3];
   logic       ov  [3];

   int total = 0;
   int bad   = 0;
   logic [7:0] rc_tab [16];

   always #5 CLK = ~CLK;

   aes_round_ctrl #(.NUM_ROUNDS(10), .RW(4)) dut10 (
      .CLK(CLK), .RSTB(RSTB), .start_valid(sv[0]), .start_ready(sr[0]), .abort(ab[0]),
      .load_sel(ls[0]), .state_en(se[0]), .key_en(ke[0]), .mix_en(me[0]), .rcon(rc[0]),
      .round_idx(ri[0]), .busy(bz[0]), .out_valid(ov[0]), .out_ready(ordy[0]));
   aes_round_ctrl #(.NUM_ROUNDS(2), .RW(4)) dut2 (
      .CLK(CLK), .RSTB(RSTB), .start_valid(sv[1]), .start_ready(sr[1]), .abort(ab[1]),
      .load_sel(ls[1]), .state_en(se[1]), .key_en(ke[1]), .mix_en(me[1]), .rcon(rc[1]),
      .round_idx(ri[1]), .busy(bz[1]), .out_valid(ov[1]), .out_ready(ordy[1]));
   aes_round_ctrl #(.NUM_ROUNDS(14), .RW(4)) dut14 (
      .CLK(CLK), .RSTB(RSTB), .start_valid(sv[2]), .start_ready(sr[2]), .abort(ab[2]),
      .load_sel(ls[2]), .state_en(se[2]), .key_en(ke[2]), .mix_en(me[2]), .rcon(rc[2]),
      .round_idx(ri[2]), .busy(bz[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

   function automatic obs_t get(input int w);
      obs_t o;
      o = '{sr:sr[w], ls:ls[w], se:se[w], ke:ke[w], me:me[w], rc:rc[w], ri:ri[w], bz:bz[w], ov:ov[w]};
      return o;
   endfunction

   // Expected outputs in cycle k after the handshake (k=0: idle)
   function automatic obs_t model(input int n, input int k);
      obs_t o;
      o = '0;
      if (k == 0) begin
         o.sr = 1'b1;
      end else if (k == 1) begin
         o.ls = 1'b1; o.se = 1'b1; o.ke = 1'b1; o.bz = 1'b1;
      end else if (k <= n) begin
         o.se = 1'b1; o.ke = 1'b1; o.me = 1'b1; o.bz = 1'b1;
         o.ri = 4'(k - 1); o.rc = rc_tab[k-1];
      end else if (k == n + 1) begin
         o.se = 1'b1; o.ke = 1'b1; o.bz = 1'b1;
         o.ri = 4'(n); o.rc = rc_tab[n];
      end else begin
         o.ov = 1'b1; o.ri = 4'(n);
      end
      return o;
   endfunction

   task automatic idle_inputs();
      for (int i = 0; i < 3; i++) begin
         sv[i] = 1'b0; ab[i] = 1'b0; ordy[i] = 1'b0;
      end
   endtask

   // One block on instance w with NUM_ROUNDS n. wait_n DONE cycles with
   // out_ready low; abort_k>0 raises abort during cycle abort_k. Outside
   // DONE, start_valid and out_ready are randomised since both must be ignored.
   task automatic run_block(input int w, input int n, input int wait_n, input int abort_k,
                            input string name);
      obs_t exp, got;
      int   last, lat, nload;
      last  = n + 2 + wait_n;
      lat   = -1;
      nload = 0;
      @(negedge CLK);
      total++;
      if (sr[w] !== 1'b1) begin
         bad++; $display("FAIL %s start_ready got=%b want=1", name, sr[w]);
      end
      sv[w] = 1'b1; ordy[w] = 1'b0; ab[w] = 1'b0;
      for (int k = 1; k <= last; k++) begin
         @(negedge CLK);
         exp = model(n, k);
         got = get(w);
         if (k >= n + 2) got.rc = '0;
         if (got.ov && lat < 0) lat = k;
         if (got.ls) nload++;
         total++;
         if (got !== exp) begin
            bad++; $display("FAIL %s cycle%0d got=%h want=%h", name, k, got, exp);
         end
         if (k == n + 1) begin
            total++;
            if (rc[w] !== rc_tab[n]) begin
               bad++; $display("FAIL %s final_rcon got=%h want=%h", name, rc[w], rc_tab[n]);
            end
         end
         if (k == abort_k) begin
            ab[w] = 1'b1; sv[w] = 1'($urandom); ordy[w] = 1'($urandom);
            break;
         end
         sv[w]   = (k < last) ? 1'($urandom) : 1'b0;
         ordy[w] = (k < n + 2) ? 1'($urandom) : (k >= last);
      end
      @(negedge CLK);
      total++;
      if (get(w) !== model(n, 0)) begin
         bad++; $display("FAIL %s back_to_idle got=%h want=%h", name, get(w), model(n, 0));
      end
      idle_inputs();
      if (abort_k == 0) begin
         total++;
         if (lat != n + 2) begin
            bad++; $display("FAIL %s latency got=%0d want=%0d", name, lat, n + 2);
         end
         total++;
         if (nload != 1) begin
            bad++; $display("FAIL %s load_sel_pulses got=%0d want=1", name, nload);
         end
      end
   endtask

   task automatic test_reset();
      RSTB = 1'b1;
      idle_inputs();
      #1 RSTB = 1'b0;
      #1;
      total++;
      if (get(0) !== model(10, 0)) begin
         bad++; $display("FAIL reset got=%h want=%h", get(0), model(10, 0));
      end
      @(negedge CLK); @(negedge CLK);
      RSTB = 1'b1;
   endtask

   task automatic test_single_block();
      run_block(0, 10, 0, 0, "single");
   endtask

   task automatic test_done_hold();
      run_block(0, 10, 5, 0, "done_hold");
   endtask

   task automatic test_abort();
      run_block(0, 10, 0, 6, "abort_r5");
      repeat (3) begin
         @(negedge CLK);
         total++;
         if (ov[0] !== 1'b0 || se[0] !== 1'b0) begin
            bad++; $display("FAIL abort_quiet ov=%b se=%b want 0 0", ov[0], se[0]);
         end
      end
      run_block(0, 10, 0, 0, "after_abort");
   endtask

   task automatic test_async_reset();
      @(negedge CLK);
      sv[0] = 1'b1;
      @(negedge CLK);
      sv[0] = 1'b0;
      repeat (4) @(negedge CLK);
      #2 RSTB = 1'b0;
      #1;
      total++;
      if (get(0) !== model(10, 0)) begin
         bad++; $display("FAIL async_reset got=%h want=%h", get(0), model(10, 0));
      end
      @(negedge CLK);
      RSTB = 1'b1;
      sv[0] = 1'b1; ab[0] = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         total++;
         if (get(0) !== model(10, 0)) begin
            bad++; $display("FAIL abort_and_start got=%h want=%h", get(0), model(10, 0));
         end
      end
      idle_inputs();
   endtask

   task automatic test_param_sweep();
      run_block(1, 2, 0, 0, "n2");
      run_block(2, 14, 0, 0, "n14");
      run_block(1, 2, 2, 0, "n2_hold");
   endtask

   task automatic test_random();
      int n, w, wt, ak;
      for (int it = 0; it < 10; it++) begin
         w  = $urandom_range(0, 2);
         n  = (w == 0) ? 10 : (w == 1) ? 2 : 14;
         wt = $urandom_range(0, 4);
         ak = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n + 2 + wt) : 0;
         repeat ($urandom_range(0, 3)) @(negedge CLK);
         run_block(w, n, wt, ak, "random");
      end
   endtask

   initial begin
      rc_tab[0] = 8'h00;
      rc_tab[1] = 8'h01;
      for (int r = 2; r < 16; r++)
         rc_tab[r] = 8'((rc_tab[r-1] * 2) % 256) ^ ((rc_tab[r-1] >= 8'd128) ? 8'h1B : 8'h00);
      test_reset();
      test_single_block();
      test_done_hold();
      test_abort();
      test_async_reset();
      test_param_sweep();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
